// File: rtl/datalink_responder_pkg.sv
// Shared definitions for both ends of the datalink bus: FSM encoding and default bus timing.
package datalink_responder_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StStuck,
        StRx,
        StTurn,
        StTx
    } dl_state_e;

    // Default bus timing, shared so initiator and responder agree on slot positions.
    localparam int unsigned DefStartMin     = 8;
    localparam int unsigned DefStartTimeout = 32;
    localparam int unsigned DefBitCycles    = 10;
    localparam int unsigned DefSampleAt     = 5;
    localparam int unsigned DefTurnCycles   = 4;

    // Frame length in cycles from t=0 to line release (8 RX slots, turnaround, 8 TX slots).
    function automatic int unsigned frame_len(input int unsigned bit_cycles,
                                              input int unsigned turn_cycles);
        return 16 * bit_cycles + turn_cycles;
    endfunction

endpackage

// File: rtl/datalink_sync.sv
// Two-flop synchronizer for the datalink pin plus edge detect on the synchronized view.
module datalink_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic line_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q, s2_q, prev_q;

    // Reset low so a line still held low after reset never looks like a high-to-low edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            s1_q   <= line_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign sync_o = s2_q;
    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/datalink_responder.sv
// Responder end of the single-wire open-drain datalink: qualifies a start pulse, receives a
// command byte MSB-first, then drives the latched response byte back after a turnaround.
module datalink_responder
    import datalink_responder_pkg::*;
#(
    parameter int unsigned START_MIN     = DefStartMin,
    parameter int unsigned START_TIMEOUT = DefStartTimeout,
    parameter int unsigned BIT_CYCLES    = DefBitCycles,
    parameter int unsigned SAMPLE_AT     = DefSampleAt,
    parameter int unsigned TURN_CYCLES   = DefTurnCycles
) (
    input  logic       clk_50khz,
    input  logic       rst_n,
    input  logic       Locked,
    inout  wire        datalink,
    input  logic [7:0] rsp_data,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    output logic       status,
    output logic       err
);

    localparam int unsigned LW = $clog2(START_TIMEOUT + 1);
    localparam int unsigned PW = $clog2(BIT_CYCLES);
    localparam int unsigned TW = $clog2(frame_len(BIT_CYCLES, TURN_CYCLES) + 1);

    localparam logic [PW-1:0] PhLast   = PW'(BIT_CYCLES - 1);
    localparam logic [PW-1:0] PhSample = PW'(SAMPLE_AT);
    localparam logic [TW-1:0] RxLast   = TW'(8 * BIT_CYCLES - 1);
    localparam logic [TW-1:0] TurnLast = TW'(8 * BIT_CYCLES + TURN_CYCLES - 1);
    localparam logic [TW-1:0] TxLast   = TW'(frame_len(BIT_CYCLES, TURN_CYCLES) - 1);

    dl_state_e   state_q, state_d;
    logic [LW-1:0] low_cnt_q, low_cnt_d;
    logic [TW-1:0] t_q, t_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  cmd_data_q, cmd_data_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        err_q, err_d;
    logic        status_q, status_d;
    logic        drv_low_q, drv_low_d;

    logic line_sync, line_rise, line_fall;

    datalink_sync u_sync (
        .clk_i  (clk_50khz),
        .rst_ni (rst_n),
        .line_i (datalink),
        .sync_o (line_sync),
        .rise_o (line_rise),
        .fall_o (line_fall)
    );

    // Next-state and output logic; t counts frame cycles, ph tracks position within a slot.
    always_comb begin
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        t_d         = t_q;
        ph_d        = ph_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = 1'b0;
        err_d       = 1'b0;
        status_d    = status_q;
        drv_low_d   = drv_low_q;

        // Response byte is captured in the cycle cmd_valid is presented.
        if (cmd_valid_q) tx_d = rsp_data;

        if (state_q inside {StRx, StTurn, StTx}) begin
            t_d  = t_q + TW'(1);
            ph_d = (ph_q == PhLast) ? '0 : ph_q + PW'(1);
        end

        unique case (state_q)
            StIdle: begin
                // A fall implies a high was observed first.
                if (line_fall) begin
                    state_d   = StStart;
                    low_cnt_d = LW'(1);
                end
            end
            StStart: begin
                if (line_rise) begin
                    if (low_cnt_q >= LW'(START_MIN)) begin
                        state_d  = StRx;
                        status_d = 1'b1;
                        t_d      = TW'(1);
                        ph_d     = PW'(1);
                    end else begin
                        state_d = StIdle;
                    end
                end else if (low_cnt_q == LW'(START_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StStuck;
                end else begin
                    low_cnt_d = low_cnt_q + LW'(1);
                end
            end
            StStuck: begin
                if (line_sync) state_d = StIdle;
            end
            StRx: begin
                if (ph_q == PhSample) shift_d = {shift_q[6:0], line_sync};
                if (t_q == RxLast) begin
                    cmd_data_d  = shift_q;
                    cmd_valid_d = 1'b1;
                    state_d     = StTurn;
                end
            end
            StTurn: begin
                if (t_q == TurnLast) begin
                    state_d   = StTx;
                    ph_d      = '0;
                    drv_low_d = ~tx_q[7];
                end
            end
            StTx: begin
                if (ph_q == PhLast) begin
                    if (t_q == TxLast) begin
                        drv_low_d = 1'b0;
                        status_d  = 1'b0;
                        state_d   = StIdle;
                    end else begin
                        drv_low_d = ~tx_q[6];
                        tx_d      = {tx_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Losing the clock qualifier abandons any frame without reporting it.
        if (!Locked) begin
            state_d     = StIdle;
            status_d    = 1'b0;
            drv_low_d   = 1'b0;
            cmd_valid_d = 1'b0;
            err_d       = 1'b0;
            cmd_data_d  = cmd_data_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_50khz or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            low_cnt_q   <= '0;
            t_q         <= '0;
            ph_q        <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            err_q       <= 1'b0;
            status_q    <= 1'b0;
            drv_low_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            low_cnt_q   <= low_cnt_d;
            t_q         <= t_d;
            ph_q        <= ph_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            err_q       <= err_d;
            status_q    <= status_d;
            drv_low_q   <= drv_low_d;
        end
    end

    assign datalink  = drv_low_q ? 1'b0 : 1'bz;
    assign cmd_data  = cmd_data_q;
    assign cmd_valid = cmd_valid_q;
    assign status    = status_q;
    assign err       = err_q;

endmodule

// File: tb/tb_datalink_responder.sv
// Randomized scoreboard bench for datalink_responder: stimulus tasks push expected events,
// a negedge monitor compares the DUT against a timing model of the bus protocol.
`timescale 1ns / 1ps
module tb_datalink_responder;

    localparam int B             = 10;
    localparam int START_MIN     = 8;
    localparam int START_TIMEOUT = 32;
    localparam int CMD_AT        = 80;   // t of cmd_valid
    localparam int TX_AT         = 84;   // t of first driven TX cycle
    localparam int REL_AT        = 164;  // t of line release

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b1;
    logic       tb_low = 1'b0;
    logic [7:0] rsp_data = 8'h00;
    logic [7:0] cmd_data;
    logic       cmd_valid;
    logic       status;
    logic       err;
    wire        datalink;

    pullup (datalink);
    assign datalink = tb_low ? 1'b0 : 1'bz;

    datalink_responder dut (
        .clk_50khz (clk),
        .rst_n     (rst_n),
        .Locked    (locked),
        .datalink  (datalink),
        .rsp_data  (rsp_data),
        .cmd_data  (cmd_data),
        .cmd_valid (cmd_valid),
        .status    (status),
        .err       (err)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         t0;
        int         cut;
        logic [7:0] rsp;
    } win_t;

    typedef struct {
        int         cyc;
        logic [7:0] cmd;
    } cmdexp_t;

    win_t    wins[$];
    cmdexp_t cq[$];
    int      eq[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame: low_len pin-low cycles, then 8 MSB-first slots (each slot starts high).
    // abort: 0 none, 1 drop Locked at t=40, 2 assert reset at t=100.
    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] rsp, input int low_len,
                              input int abort);
        int      p, t0, cut;
        win_t    w;
        cmdexp_t ce;
        rsp_data = rsp;
        tb_low   = 1'b1;
        repeat (low_len) next_cycle();
        tb_low = 1'b0;
        p      = cyc;
        t0     = p + 2;
        cut    = (abort == 1) ? t0 + 41 : (abort == 2) ? t0 + 100 : t0 + REL_AT;
        w.t0   = t0;
        w.cut  = cut;
        w.rsp  = rsp;
        wins.push_back(w);
        if (cut > t0 + CMD_AT) begin
            ce.cyc = t0 + CMD_AT;
            ce.cmd = cmd;
            cq.push_back(ce);
        end
        for (int k = 0; k < 8 * B; k++) begin
            if (abort == 1 && cyc == t0 + 40) break;
            tb_low = (k % B != 0) && !cmd[7 - k / B];
            next_cycle();
        end
        tb_low = 1'b0;
        if (abort == 1) begin
            locked = 1'b0;
            repeat (5) next_cycle();
            locked = 1'b1;
            repeat (5) next_cycle();
        end else begin
            while (cyc < t0 + CMD_AT + 1) next_cycle();
            rsp_data = ~rsp;  // response must already be latched
            if (abort == 2) begin
                while (cyc < t0 + 100) next_cycle();
                rst_n = 1'b0;
                repeat (3) next_cycle();
                rst_n = 1'b1;
                repeat (3) next_cycle();
            end else begin
                while (cyc < t0 + REL_AT) next_cycle();
            end
        end
    endtask

    task automatic glitch(input int len);
        tb_low = 1'b1;
        repeat (len) next_cycle();
        tb_low = 1'b0;
        repeat (4) next_cycle();
    endtask

    task automatic stuck_low(input int len);
        eq.push_back(cyc + 34);  // 32nd synchronized low cycle, err one cycle later
        tb_low = 1'b1;
        repeat (len) next_cycle();
        tb_low = 1'b0;
        repeat (6) next_cycle();
    endtask

    // Monitor: compares every cycle against the protocol timing model.
    initial begin
        logic [7:0] model_cmd;
        logic       exp_valid, exp_err, exp_status, exp_pin;
        int         lo, hi, tmp;
        cmdexp_t    ce;
        model_cmd = 8'h00;
        forever begin
            @(negedge clk);
            exp_valid = (cq.size() > 0) && (cq[0].cyc == cyc);
            chk("cmd_valid", {7'b0, cmd_valid}, {7'b0, exp_valid});
            if (exp_valid) begin
                model_cmd = cq[0].cmd;
                ce = cq.pop_front();
            end
            if (!rst_n) model_cmd = 8'h00;
            chk("cmd_data", cmd_data, model_cmd);
            exp_err = (eq.size() > 0) && (eq[0] == cyc);
            chk("err", {7'b0, err}, {7'b0, exp_err});
            if (exp_err) tmp = eq.pop_front();
            exp_status = 1'b0;
            exp_pin    = 1'b1;
            foreach (wins[i]) begin
                hi = (wins[i].cut < wins[i].t0 + REL_AT) ? wins[i].cut : wins[i].t0 + REL_AT;
                if (cyc >= wins[i].t0 + 1 && cyc < hi) exp_status = 1'b1;
                lo = wins[i].t0 + TX_AT;
                if (cyc >= lo && cyc < hi) exp_pin = wins[i].rsp[7 - (cyc - lo) / B];
            end
            chk("status", {7'b0, status}, {7'b0, exp_status});
            if (!tb_low) chk("datalink", {7'b0, datalink}, {7'b0, exp_pin});
        end
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) next_cycle();
        rst_n = 1'b1;
        repeat (5) next_cycle();

        send_frame(8'hA5, 8'h3C, START_MIN + 2, 0);
        repeat (5) next_cycle();
        glitch(5);
        stuck_low(40);
        send_frame(8'h5A, 8'hC3, 12, 0);
        repeat (5) next_cycle();
        send_frame(8'h96, 8'h69, 9, 1);
        send_frame(8'h33, 8'hE7, 10, 2);
        send_frame(8'h4B, 8'hD2, 10, 0);
        repeat (4) next_cycle();
        send_frame(8'h01, 8'h81, 10, 0);
        repeat (2) next_cycle();
        send_frame(8'hFE, 8'h7E, 10, 0);

        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(3, 12)) next_cycle();
            if ($urandom_range(0, 1) == 1) glitch(int'($urandom_range(1, START_MIN - 1)));
            send_frame(8'($urandom), 8'($urandom),
                       int'($urandom_range(START_MIN, START_TIMEOUT - 1)), 0);
        end

        repeat (10) next_cycle();
        chk("pending_cmd", 8'(cq.size()), 8'h00);
        chk("pending_err", 8'(eq.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/datalink_responder.md
# datalink_responder

Responder end of the single-wire, open-drain `datalink` bus clocked from the 50 kHz domain. It detects an initiator's start pulse and receives an 8-bit command MSB-first. It presents the command to local logic and latches an 8-bit response, then drives that response back on the same wire after a fixed turnaround. It sits opposite the trigger-driven initiator on the board-level datalink and shares its `clk_50khz` / `Locked` environment.

## Interface
Parameters:
- `START_MIN`, 8: minimum synchronized low cycles qualifying a start pulse.
- `START_TIMEOUT`, 32: low cycles after which the start pulse is declared a stuck line.
- `BIT_CYCLES`, 10: cycles per bit slot, both directions.
- `SAMPLE_AT`, 5: sample offset within an RX slot; legal range 1..`BIT_CYCLES`-2.
- `TURN_CYCLES`, 4: gap between the last RX slot and the first TX slot.

Ports:
- `clk_50khz` in 1: the single clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `Locked` in 1: clock-ready qualifier. When low, the block is held idle.
- `datalink` inout 1: open-drain bus. The block only ever drives 0 or Z.
- `rsp_data` in 8: response byte, sampled in the `cmd_valid` cycle.
- `cmd_data` out 8: last received command, held until the next valid frame.
- `cmd_valid` out 1: one-cycle pulse when `cmd_data` updates.
- `status` out 1: high while a frame is in progress, from start qualification to TX release.
- `err` out 1: one-cycle pulse on a start timeout.

## Operation
- The input path uses a 2-flop synchronizer on `datalink`. All thresholds count synchronized cycles.
- Output path: the registered `drv_low` flag gives `datalink` = 0 when set, Z otherwise.
- States:
  - IDLE: waits for a synchronized high followed by a low. The low counter then starts, and the state goes to START.
  - START: counts low cycles.
    - A rise with count < `START_MIN` is a glitch: return to IDLE with no outputs.
    - A rise with count ≥ `START_MIN` qualifies the start. Set `status`=1, set t=0, go to RX.
    - If count reaches `START_TIMEOUT`: pulse `err` and go to STUCK.
  - STUCK: waits for the line to go high, then returns to IDLE.
  - RX: samples bit i (MSB first) at t = i·`BIT_CYCLES` + `SAMPLE_AT` into a shift register. Line low = 0.
    - At t = 8·`BIT_CYCLES`: load `cmd_data`, pulse `cmd_valid`, latch `rsp_data`, go to TURN.
  - TURN: waits `TURN_CYCLES`, then goes to TX.
  - TX: for slot j = 0..7, `drv_low` = ~rsp[7-j] for all `BIT_CYCLES` cycles of the slot. The line is not monitored; there is no collision detection.
    - After slot 7: `drv_low`=0, `status`=0, go to IDLE.
- `Locked`=0 at any time: the next cycle releases the line, clears `status`, and forces IDLE. No `cmd_valid` and no `err` are generated. A partial command is discarded and `cmd_data` keeps its old value.
- Async reset mid-frame: same effect, plus all outputs go to their reset values.
- IDLE requires an observed high before accepting a new start, so a line held low at TX release is never taken as a start.

## Timing
- Reset values:
  - `datalink` = Z (`drv_low`=0)
  - `cmd_data` = 8'h00
  - `cmd_valid` = 0
  - `status` = 0
  - `err` = 0
- Synchronizer latency: 2 cycles from pin to synchronized view. t=0 is the first cycle in which the synchronized line is high after a qualified start.
- With default parameters:
  - RX samples at t = 5, 15, …, 75.
  - `cmd_valid` at t = 80.
  - TX slot 0 is driven on the pin from t = 84, slot 7 ends at t = 163.
  - Line released and `status` low at t = 164.
- Counter widths: ceil(log2) of the largest count each counter reaches. The frame counter must hold 16·`BIT_CYCLES` + `TURN_CYCLES`.
- `cmd_valid` and `err` never coincide. `err` requires START and `cmd_valid` requires RX.

## Structure
- The shared package/header holds:
  - the state encoding (IDLE, START, STUCK, RX, TURN, TX)
  - default values of all five timing parameters, so the initiator and responder agree on bus timing.
- Sub-module `datalink_sync`: 2-flop synchronizer plus rise/fall detect of the synchronized line. The initiator side reuses it.

## Test plan
- Command 8'hA5 with `START_MIN`+2 low cycles and `rsp_data`=8'h3C. Required: `cmd_valid` at t=80 with `cmd_data`=8'hA5, then the pin shows 0,0,1,1,1,1,0,0 per 10-cycle slot from t=84, and is released at t=164.
- Low pulse of 5 cycles. Required: no `status`, no `cmd_valid`, and `cmd_data` unchanged.
- Line held low for 40 cycles. Required: `err` pulses once at low-count 32, the block stays in STUCK until the line rises, and the next valid frame is then received normally.
- `Locked` dropped at t=40 during RX. Required: `status`=0 the next cycle, no `cmd_valid`, `cmd_data` keeps its previous value, and the line stays Z.
- `rst_n` asserted at t=100 during TX. Required: line Z immediately and all outputs at reset values. A full frame sent after release returns the correct response.
- Two back-to-back frames 8'h01 then 8'hFE, with the second start 2 cycles after TX release. Required: both commands are received and both responses are driven.
